// File: rtl/vx_tc_rf_reader.sv
// Tensor-core operand fetch: borrows the rs3 read port to burst-read N GPR rows and returns them packed.
// Optional TC_RF_READER_PERF_EN adds perf_rows / perf_steal_cycles counters.
module vx_tc_rf_reader #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int ADDRW       = 8,
  parameter int NR_BITS     = 5,
  parameter int MAX_REGS    = 8,
  parameter int CNTW        = $clog2(MAX_REGS + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [ADDRW-1:0]                     req_addr,
  input  logic [CNTW-1:0]                      req_count,
  output logic                                 tc_rf_valid,
  output logic [ADDRW-1:0]                     tc_rf_addr,
  input  logic [NUM_THREADS*XLEN-1:0]          tc_rf_data,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [MAX_REGS*NUM_THREADS*XLEN-1:0] rsp_data,
  output logic                                 busy
`ifdef TC_RF_READER_PERF_EN
  ,
  output logic [31:0]                          perf_rows,
  output logic [31:0]                          perf_steal_cycles
`endif
);

  localparam int ROW_W = NUM_THREADS * XLEN;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0]   idx_q, idx_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic              rfv_q;
  logic              clr_buf;
  logic              cap_vld_q;
  logic [CNTW-1:0]   cap_idx_q;
  logic              cap_x0_q;
  logic [ROW_W-1:0]  buf_q [MAX_REGS];

  function automatic logic [CNTW-1:0] clamp_count(input logic [CNTW-1:0] c);
    return (c > CNTW'(MAX_REGS)) ? CNTW'(MAX_REGS) : c;
  endfunction

  function automatic logic is_x0(input logic [ADDRW-1:0] a);
    return a[NR_BITS-1:0] == '0;
  endfunction

  // The operand stage does not zero x0 on the stolen port, so mask it here.
  function automatic logic [ROW_W-1:0] mask_row(input logic [ROW_W-1:0] d, input logic x0);
    return x0 ? '0 : d;
  endfunction

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign tc_rf_valid = rfv_q;
  assign tc_rf_addr  = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    clr_buf = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = clamp_count(req_count);
          idx_d   = '0;
          addr_d  = req_addr;
          clr_buf = 1'b1;
          state_d = (clamp_count(req_count) == '0) ? RESP : READ;
        end
      end
      READ: begin
        if (idx_q == cnt_q - CNTW'(1)) begin
          state_d = DRAIN;
        end else begin
          idx_d  = idx_q + CNTW'(1);
          addr_d = addr_q + ADDRW'(1);
        end
      end
      DRAIN: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: state, read address and the one-cycle capture shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      rfv_q     <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      cap_x0_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      rfv_q     <= (state_d == READ);
      cap_vld_q <= rfv_q;
      cap_idx_q <= idx_q;
      cap_x0_q  <= is_x0(addr_q);
    end
  end

  // Capture stage: data returns one cycle after the address
  always_ff @(posedge clk) begin
    if (reset || clr_buf) begin
      for (int r = 0; r < MAX_REGS; r++) buf_q[r] <= '0;
    end else if (cap_vld_q) begin
      for (int r = 0; r < MAX_REGS; r++) begin
        if (cap_idx_q == CNTW'(r)) buf_q[r] <= mask_row(tc_rf_data, cap_x0_q);
      end
    end
  end

  always_comb begin
    rsp_data = '0;
    for (int r = 0; r < MAX_REGS; r++) rsp_data[r*ROW_W +: ROW_W] = buf_q[r];
  end

`ifdef TC_RF_READER_PERF_EN
  logic [31:0] perf_rows_q, perf_steal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rows_q  <= '0;
      perf_steal_q <= '0;
    end else begin
      if (cap_vld_q) perf_rows_q <= perf_rows_q + 32'd1;
      if (rfv_q) perf_steal_q <= perf_steal_q + 32'd1;
    end
  end

  assign perf_rows         = perf_rows_q;
  assign perf_steal_cycles = perf_steal_q;
`endif

endmodule
